serial_pattern_detector: RTL and testbench
==========================================

Name: serial_pattern_detector

Overview:
- Downstream consumer of the sr_to_d_flipflop Q output. It samples the registered serial bit stream one bit per qualified clock and detects a fixed PAT_LEN-bit pattern, with overlapping matches allowed.
- It emits a one-cycle match pulse and keeps a saturating match counter, so benches and higher-level logic can check a flip-flop-driven bit sequence without waveform inspection.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, target sequence in arrival order: MSB is the oldest bit, LSB is the newest.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data, normally the flip-flop Q.
- bit_valid  input  1  bit_in is sampled only on edges where this is 1.
- clear_cnt  input  1  synchronous clear of match_count and saturated.
- match  output  1  one-cycle pulse: the pattern completed on the previous sampling edge.
- match_count  output  CNT_W  number of matches since reset or clear; saturating.
- saturated  output  1  sticky; set when match_count reaches all-ones.
- armed  output  1  1 once PAT_LEN valid bits have been received since reset.

Behaviour:
- Reset (sampled on the rising edge of clk with reset=1) forces:
  - shift history = 0, fill count = 0, FSM = FILL;
  - match = 0, match_count = 0, saturated = 0, armed = 0.
  - Reset overrides every other input. Asserting reset mid-stream discards all history; a partial pattern is never completed across a reset.
- Shift register:
  - On an edge with bit_valid=1: hist <= {hist[PAT_LEN-2:0], bit_in}.
  - On an edge with bit_valid=0: hist, fill count and FSM hold, and match <= 0.
- FSM, two states:
  - FILL: fill count increments per valid bit. When the PAT_LEN-th valid bit is shifted in, move to HUNT and set armed <= 1 on that same edge. That completing bit is compared, so a match is possible on exactly the PAT_LEN-th bit.
  - HUNT: stays in HUNT until reset. armed stays 1.
- Match:
  - Let next_hist be the shifted value.
  - On a valid edge, match <= (next_hist == PATTERN) && (state==HUNT || fill count == PAT_LEN-1).
  - match is registered: it is high for exactly the one cycle after the completing bit's edge.
  - Overlap is permitted. History is never flushed on a match.
- Counter:
  - On the same edge that sets match, match_count <= match_count+1 unless it is already all-ones. It holds at 2^CNT_W-1.
  - saturated <= 1 on the edge where the count becomes all-ones. It stays 1 until reset or clear_cnt.
- clear_cnt:
  - Sets match_count <= 0 and saturated <= 0.
  - Priority over a coincident match: that match still pulses `match` but is not counted.
  - Does not affect hist, FSM, armed or match.
- Latency: one clock from the sampling edge of the final pattern bit to match=1 and the count update.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then valid bits 1,0,1,1 on consecutive edges -> armed=1 after the 4th edge. match=1 for one cycle after the 4th edge. match_count=1.
- Continue with 0,1,1 -> overlapping match after the 7th bit. match_count=2. match is high for exactly 2 cycles in total.
- Insert bit_valid=0 for 3 cycles between bits 2 and 3 of 1,0,1,1 -> same single match, delayed by 3 cycles. No match pulses during the gap.
- Send 1,0,1 then assert reset for 1 cycle, then 1 -> no match. armed=0. The FSM refills from zero.
- With CNT_W=2, produce 4 matches of overlapping 1011 -> count goes 1,2,3,3. saturated=1 from the 3rd match. Then clear_cnt=1 -> count=0, saturated=0.
- Assert clear_cnt on the same edge a match completes with count=5 -> match pulses, count=0 next cycle.

Source files
------------

// File: rtl/serial_pattern_detector_if.sv
// Serial bit stream in, match/count status out, between a bit source and the pattern detector.
interface serial_pattern_detector_if #(
    parameter int CNT_W = 8
) ();
    logic             bit_in;
    logic             bit_valid;
    logic             clear_cnt;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             saturated;
    logic             armed;

    modport master (
        output bit_in, bit_valid, clear_cnt,
        input  match, match_count, saturated, armed
    );

    modport slave (
        input  bit_in, bit_valid, clear_cnt,
        output match, match_count, saturated, armed
    );
endinterface

// File: rtl/serial_pattern_detector.sv
// Detects a fixed PAT_LEN-bit pattern in a qualified serial stream (overlap allowed),
// emitting a one-cycle match pulse and a saturating match counter.
module serial_pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input logic                       clk,
    input logic                       reset,
    serial_pattern_detector_if.slave  bus
);
    localparam int                 FILL_W    = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0]  LAST_FILL = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic {S_FILL, S_HUNT} state_t;

    state_t             r_state;
    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;
    logic               r_sat;
    logic               r_armed;

    logic [PAT_LEN-1:0] w_next_hist;
    logic               w_hit;
    logic [CNT_W-1:0]   w_count_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // The completing bit of the first window is already eligible to match.
    assign w_next_hist = {r_hist[PAT_LEN-2:0], bus.bit_in};
    assign w_hit       = (w_next_hist == PATTERN) &&
                         ((r_state == S_HUNT) || (r_fill == LAST_FILL));
    assign w_count_inc = sat_inc(r_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
            r_count <= '0;
            r_sat   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (bus.bit_valid) begin
                r_hist  <= w_next_hist;
                r_match <= w_hit;
                case (r_state)
                    S_FILL: begin
                        if (r_fill == LAST_FILL) begin
                            r_state <= S_HUNT;
                            r_armed <= 1'b1;
                        end else begin
                            r_fill <= r_fill + 1'b1;
                        end
                    end
                    default: r_armed <= 1'b1;
                endcase
            end
            // A coincident clear wins: the match still pulses but is not counted.
            if (bus.clear_cnt) begin
                r_count <= '0;
                r_sat   <= 1'b0;
            end else if (bus.bit_valid && w_hit) begin
                r_count <= w_count_inc;
                if (w_count_inc == CNT_MAX) r_sat <= 1'b1;
            end
        end
    end

    assign bus.match       = r_match;
    assign bus.match_count = r_count;
    assign bus.saturated   = r_sat;
    assign bus.armed       = r_armed;
endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: directed vector table, hand-written corner sequences,
// and random traffic against a window-based reference model, on 8-bit and 2-bit counter builds.
module tb_serial_pattern_detector;
    logic clk;
    logic reset;

    serial_pattern_detector_if #(.CNT_W(8)) if8 ();
    serial_pattern_detector_if #(.CNT_W(2)) if2 ();

    serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.slave)
    );

    serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: last (up to) 4 valid bits since reset, plus per-width counters.
    bit q[$];
    bit m_match, m_armed, m_sat8, m_sat2;
    int m_cnt8, m_cnt2;

    typedef struct {
        bit rst;
        bit v;
        bit b;
        bit c;
        bit m;
        int cnt;
        bit armed;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit v, input bit b, input bit c);
        bit hit;
        hit = 1'b0;
        if (rst) begin
            q.delete();
            m_match = 0; m_armed = 0;
            m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 0; m_sat2 = 0;
        end else begin
            if (v) begin
                q.push_back(b);
                if (q.size() > 4) void'(q.pop_front());
                if (q.size() == 4) begin
                    m_armed = 1;
                    hit = ({q[0], q[1], q[2], q[3]} == 4'b1011);
                end
            end
            m_match = hit;
            if (c) begin
                m_cnt8 = 0; m_sat8 = 0; m_cnt2 = 0; m_sat2 = 0;
            end else if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt8 == 255) m_sat8 = 1;
                if (m_cnt2 < 3) m_cnt2++;
                if (m_cnt2 == 3) m_sat2 = 1;
            end
        end
    endtask

    task automatic compare_model();
        check("match8",  32'(if8.match),       32'(m_match));
        check("count8",  32'(if8.match_count), 32'(m_cnt8));
        check("sat8",    32'(if8.saturated),   32'(m_sat8));
        check("armed8",  32'(if8.armed),       32'(m_armed));
        check("match2",  32'(if2.match),       32'(m_match));
        check("count2",  32'(if2.match_count), 32'(m_cnt2));
        check("sat2",    32'(if2.saturated),   32'(m_sat2));
        check("armed2",  32'(if2.armed),       32'(m_armed));
    endtask

    task automatic step(input bit rst, input bit v, input bit b, input bit c);
        reset = rst;
        if8.bit_valid = v; if8.bit_in = b; if8.clear_cnt = c;
        if2.bit_valid = v; if2.bit_in = b; if2.clear_cnt = c;
        @(posedge clk);
        model_edge(rst, v, b, c);
        #1;
        compare_model();
    endtask

    task automatic add(input bit r, input bit v, input bit b, input bit c,
                       input bit m, input int cnt, input bit a);
        vec_t e;
        e.rst = r; e.v = v; e.b = b; e.c = c; e.m = m; e.cnt = cnt; e.armed = a;
        tbl.push_back(e);
    endtask

    task automatic bits(input logic [31:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) step(0, 1, pat[i], 0);
    endtask

    initial begin
        reset = 1'b1;
        if8.bit_valid = 0; if8.bit_in = 0; if8.clear_cnt = 0;
        if2.bit_valid = 0; if2.bit_in = 0; if2.clear_cnt = 0;

        // Basic match then overlap
        add(1,0,0,0, 0,0,0);
        add(0,1,1,0, 0,0,0); add(0,1,0,0, 0,0,0); add(0,1,1,0, 0,0,0);
        add(0,1,1,0, 1,1,1);
        add(0,1,0,0, 0,1,1); add(0,1,1,0, 0,1,1); add(0,1,1,0, 1,2,1);
        add(0,0,0,0, 0,2,1);
        // Gap of three invalid cycles inside the pattern
        add(1,0,0,0, 0,0,0);
        add(0,1,1,0, 0,0,0); add(0,1,0,0, 0,0,0);
        add(0,0,1,0, 0,0,0); add(0,0,1,0, 0,0,0); add(0,0,1,0, 0,0,0);
        add(0,1,1,0, 0,0,0); add(0,1,1,0, 1,1,1); add(0,0,0,0, 0,1,1);
        // Reset mid-pattern discards history; refill needs four fresh bits
        add(1,0,0,0, 0,0,0);
        add(0,1,1,0, 0,0,0); add(0,1,0,0, 0,0,0); add(0,1,1,0, 0,0,0);
        add(1,0,0,0, 0,0,0);
        add(0,1,1,0, 0,0,0); add(0,1,0,0, 0,0,0); add(0,1,1,0, 0,0,0);
        add(0,1,1,0, 1,1,1);
        // Clear without a match
        add(0,0,0,1, 0,0,1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].c);
            check($sformatf("tbl%0d_match", i), 32'(if8.match),       32'(tbl[i].m));
            check($sformatf("tbl%0d_count", i), 32'(if8.match_count), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_armed", i), 32'(if8.armed),       32'(tbl[i].armed));
        end

        // Saturation on the 2-bit counter and clear coincident with a match at count 5
        step(1, 0, 0, 0);
        bits(32'b1011, 4);
        check("sat_seq_c2_1", 32'(if2.match_count), 1);
        bits(32'b011, 3);
        check("sat_seq_c2_2", 32'(if2.match_count), 2);
        check("sat_seq_s2_2", 32'(if2.saturated), 0);
        bits(32'b011, 3);
        check("sat_seq_c2_3", 32'(if2.match_count), 3);
        check("sat_seq_s2_3", 32'(if2.saturated), 1);
        bits(32'b011, 3);
        check("sat_seq_c2_4", 32'(if2.match_count), 3);
        check("sat_seq_s2_4", 32'(if2.saturated), 1);
        bits(32'b011, 3);
        check("clr_pre_c8", 32'(if8.match_count), 5);
        bits(32'b01, 2);
        step(0, 1, 1, 1);
        check("clr_hit_m8", 32'(if8.match), 1);
        check("clr_hit_c8", 32'(if8.match_count), 0);
        check("clr_hit_c2", 32'(if2.match_count), 0);
        check("clr_hit_s2", 32'(if2.saturated), 0);
        step(0, 0, 0, 0);
        check("clr_after_m8", 32'(if8.match), 0);

        // Random traffic, biased towards ones so matches are frequent
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
